// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Purpose  : 8N1 UART receiver, 16x fractional-accumulator oversampling,
//            3-tap majority vote, valid/ready byte output.
//            Define RX_PARITY_EN for 8E1 framing with a parity_err pulse.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_os #(
  parameter int ACC_WIDTH = 24,
  parameter int ACC_INC   = 154619,
  parameter int OS_RATE   = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam logic [ACC_WIDTH:0] c_inc     = (ACC_WIDTH + 1)'(ACC_INC);
  localparam logic [3:0]         c_os_last = 4'(OS_RATE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef RX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  logic [ACC_WIDTH:0] r_acc;
  logic               r_sync1, r_sync2;
  state_t             r_state, w_state_nx;
  logic [3:0]         r_os_cnt, w_os_nx;
  logic [2:0]         r_bit_idx, w_idx_nx;
  logic [7:0]         r_shift, w_shift_nx;
  logic               r_tap7, r_tap8;
  logic [7:0]         r_data;
  logic               r_valid, r_overrun, r_frame_err;
  logic               w_tick, w_rx_s, w_maj, w_deliver, w_ferr;
`ifdef RX_PARITY_EN
  logic               r_par, w_par_nx, r_parity_err, w_perr;
`endif

  assign w_tick = r_acc[ACC_WIDTH];
  assign w_rx_s = r_sync2;
  assign w_maj  = (r_tap7 & r_tap8) | (r_tap7 & w_rx_s) | (r_tap8 & w_rx_s);

  // Free-running phase accumulator; the registered carry is the 16x tick.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_acc   <= '0;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_acc   <= {1'b0, r_acc[ACC_WIDTH-1:0]} + c_inc;
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_os_nx    = r_os_cnt;
    w_idx_nx   = r_bit_idx;
    w_shift_nx = r_shift;
    w_deliver  = 1'b0;
    w_ferr     = 1'b0;
`ifdef RX_PARITY_EN
    w_par_nx   = r_par;
    w_perr     = 1'b0;
`endif
    if (w_tick) begin
      w_os_nx = (r_os_cnt == c_os_last) ? 4'd0 : r_os_cnt + 4'd1;
      case (r_state)
        S_IDLE: begin
          // The detecting tick is tap 0, so the following tick sees 1.
          w_os_nx = w_rx_s ? 4'd0 : 4'd1;
          if (!w_rx_s) w_state_nx = S_START;
        end
        S_START: if (r_os_cnt == 4'd9) begin
          if (w_maj) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_DATA;
            w_idx_nx   = 3'd0;
          end
        end
        S_DATA: if (r_os_cnt == 4'd9) begin
          w_shift_nx = {w_maj, r_shift[7:1]};
          w_idx_nx   = r_bit_idx + 3'd1;
`ifdef RX_PARITY_EN
          if (r_bit_idx == 3'd7) w_state_nx = S_PARITY;
`else
          if (r_bit_idx == 3'd7) w_state_nx = S_STOP;
`endif
        end
`ifdef RX_PARITY_EN
        S_PARITY: if (r_os_cnt == 4'd9) begin
          w_par_nx   = w_maj;
          w_state_nx = S_STOP;
        end
`endif
        S_STOP: if (r_os_cnt == 4'd9) begin
          if (!w_maj) begin
            w_ferr     = 1'b1;
            w_state_nx = S_BREAK;
          end else begin
            w_state_nx = S_IDLE;
`ifdef RX_PARITY_EN
            if (r_par != ^r_shift) w_perr = 1'b1;
            else                   w_deliver = 1'b1;
`else
            w_deliver  = 1'b1;
`endif
          end
        end
        S_BREAK: if (w_rx_s) w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tap7    <= 1'b1;
      r_tap8    <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_os_cnt  <= w_os_nx;
      r_bit_idx <= w_idx_nx;
      r_shift   <= w_shift_nx;
      if (w_tick && r_os_cnt == 4'd7) r_tap7 <= w_rx_s;
      if (w_tick && r_os_cnt == 4'd8) r_tap8 <= w_rx_s;
    end
  end

  // A byte is accepted into rx_data only when the slot is free or being freed.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= w_ferr;
      if (w_deliver && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else begin
        if (w_deliver)           r_overrun <= 1'b1;
        if (r_valid && rx_ready) r_valid   <= 1'b0;
      end
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par        <= w_par_nx;
      r_parity_err <= w_perr;
    end
  end
  assign parity_err = r_parity_err;
`endif

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
